// File: rtl/delay_line_scheduler.sv
// delay_line_scheduler
//
// Per-sample sequencer for port 0 of the shared SRAM macro that holds the looper/delay ring
// buffer. Each sample_tick starts one fixed five-cycle access slot:
//   IDLE -> RD -> RDWAIT -> WR -> DONE -> IDLE
// The slot reads the delayed sample (delay mode) or the looped sample (loop mode). It then
// optionally writes the new sample at the current pointer. Next it advances the circular
// pointer. Finally it presents the read sample on dout with a one-cycle out_valid pulse.
//
// Ports
//   clk, rst_n      single clock domain, asynchronous active-low reset
//   sample_tick     one-cycle pulse per ADC sample (already synchronised)
//   record          1 = write din into the buffer this slot
//   delay_reverb    1 = delay mode (read ptr - delay_len), 0 = loop mode (read ptr)
//   delay_len       delay in samples, latched at sample_tick
//   din             new sample, latched at sample_tick
//   sram_csb0       SRAM port-0 chip select, active low
//   sram_web0       SRAM port-0 write enable, active low
//   sram_addr0      SRAM port-0 word address
//   sram_din0       SRAM write data, sample zero-extended to 32 bits
//   sram_dout0      SRAM read data, low DATA_W bits used
//   dout            sample read by the last completed slot
//   out_valid       one-cycle pulse while dout carries a freshly completed slot
//   busy            high while a slot is in progress
//   overrun         high in any cycle where sample_tick arrives while busy (tick dropped)

module delay_line_scheduler #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              record,
  input  logic              delay_reverb,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [DATA_W-1:0] din,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned DinPad = 32 - DATA_W;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRd     = 3'd1;
  localparam logic [2:0] StRdWait = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;

  // Slot registers: inputs latched at the accepted tick, so mid-slot changes are ignored.
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] len_q;
  logic              rec_q;
  logic              dr_q;

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] dout_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              slot_start;

  logic unused_dout_hi;
  assign unused_dout_hi = ^sram_dout0[31:DATA_W];

  assign slot_start = (state_q == StIdle) && sample_tick;

  // Subtraction wraps modulo the buffer depth. A zero delay therefore reads the word at ptr
  // before this slot overwrites it, which gives a full-lap delay.
  assign rd_addr = dr_q ? (ptr_q - len_q) : ptr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (sample_tick) state_d = StRd;
      StRd:     state_d = StRdWait;
      StRdWait: state_d = StWr;
      StWr:     state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      din_q   <= '0;
      len_q   <= '0;
      rec_q   <= 1'b0;
      dr_q    <= 1'b0;
      rdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (slot_start) begin
        din_q <= din;
        len_q <= delay_len;
        rec_q <= record;
        dr_q  <= delay_reverb;
      end
      // One-cycle read latency: the data for the RD access is valid during RDWAIT.
      if (state_q == StRdWait) begin
        rdata_q <= sram_dout0[DATA_W-1:0];
      end
      // Loaded on entry to DONE so dout and out_valid change together.
      if (state_q == StWr) begin
        dout_q <= rdata_q;
      end
      if (state_q == StDone) begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end

  // SRAM port 0 is decoded straight from state. An asynchronous reset therefore deasserts
  // the port in the same cycle, so no write from an aborted slot can complete.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    case (state_q)
      StRd: begin
        sram_csb0  = 1'b0;
        sram_addr0 = rd_addr;
      end
      StWr: begin
        if (rec_q) begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = ptr_q;
          sram_din0  = {{DinPad{1'b0}}, din_q};
        end
      end
      default: ;
    endcase
  end

  assign dout      = dout_q;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  // DONE counts as busy, so a tick landing on the last slot cycle is dropped as well.
  assign overrun   = sample_tick && busy;

endmodule

// File: tb/tb_delay_line_scheduler.sv
module tb_delay_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        record = 1'b0;
  logic        delay_reverb = 1'b0;
  logic [7:0]  delay_len = '0;
  logic [15:0] din = '0;
  logic        sram_csb0, sram_web0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
  logic [15:0] dout;
  logic        out_valid, busy, overrun;

  int n_checks = 0;
  int n_pass = 0;

  delay_line_scheduler #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .record       (record),
    .delay_reverb (delay_reverb),
    .delay_len    (delay_len),
    .din          (din),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0),
    .dout         (dout),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // SRAM port-0 model with an access log (1 = write) and a write counter.
  logic [31:0] mem [256];
  bit          acc_we [$];
  logic [7:0]  acc_addr [$];
  int          wr_count = 0;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (!sram_csb0) begin
      acc_we.push_back(!sram_web0);
      acc_addr.push_back(sram_addr0);
      if (!sram_web0) begin
        mem[sram_addr0] <= sram_din0;
        wr_count++;
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full slot. Inputs are scrambled after the tick to show latched values are used.
  task automatic run_slot(input logic [15:0] d, input logic rec, input logic dr,
                          input logic [7:0] dl, output logic [15:0] got);
    bit seen;
    seen = 1'b0;
    got  = '0;
    @(negedge clk);
    acc_we.delete();
    acc_addr.delete();
    sample_tick = 1'b1; din = d; record = rec; delay_reverb = dr; delay_len = dl;
    @(negedge clk);
    sample_tick = 1'b0; din = ~d; record = ~rec; delay_reverb = ~dr; delay_len = ~dl;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        got  = dout;
      end
    end
    if (!seen) check("slot_timeout", 0, 1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] rd_a, input bit has_wr,
                           input logic [7:0] wr_a);
    int n;
    n = has_wr ? 2 : 1;
    check({tag, "_nacc"}, acc_addr.size(), n);
    if (acc_addr.size() >= n) begin
      check({tag, "_rd_we"}, 32'(acc_we[0]), 0);
      check({tag, "_rd_addr"}, 32'(acc_addr[0]), 32'(rd_a));
      if (has_wr) begin
        check({tag, "_wr_we"}, 32'(acc_we[1]), 1);
        check({tag, "_wr_addr"}, 32'(acc_addr[1]), 32'(wr_a));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int wc;
    int pulses;

    // Reset state
    #2;
    check("rst_csb0", 32'(sram_csb0), 1);
    check("rst_web0", 32'(sram_web0), 1);
    check("rst_addr0", 32'(sram_addr0), 0);
    check("rst_din0", sram_din0, 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Delay mode, len 3, din=n on tick n; addresses 253..255 are still zero
    for (int n = 0; n < 8; n++) begin
      run_slot(16'(n), 1'b1, 1'b1, 8'd3, got);
      check($sformatf("delay_n%0d", n), 32'(got), (n >= 3) ? n - 3 : 0);
    end
    check_log("delay_n7", 8'd4, 1'b1, 8'd7);

    // Record 1..4 at ptr 8..11, loop a full lap, then replay them
    for (int n = 1; n <= 4; n++) run_slot(16'(n), 1'b1, 1'b0, 8'd0, got);
    for (int n = 0; n < 252; n++) run_slot(16'h0, 1'b0, 1'b0, 8'd0, got);
    for (int n = 1; n <= 4; n++) begin
      run_slot(16'h0, 1'b0, 1'b0, 8'd0, got);
      check($sformatf("loop_%0d", n), 32'(got), n);
    end
    check_log("loop_play", 8'd11, 1'b0, 8'd0);

    // Reset asserted mid-WR at ptr 12 aborts the write
    @(negedge clk);
    sample_tick = 1'b1; din = 16'h5a5a; record = 1'b1; delay_reverb = 1'b0; delay_len = 8'd0;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("midwr_web0", 32'(sram_web0), 0);
    wc = wr_count;
    rst_n = 1'b0;
    #1;
    check("midwr_rst_csb0", 32'(sram_csb0), 1);
    check("midwr_rst_web0", 32'(sram_web0), 1);
    check("midwr_rst_busy", 32'(busy), 0);
    check("midwr_rst_dout", 32'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midwr_no_write", wr_count, wc);
    check("midwr_mem12", mem[12], 0);

    // ptr restarts at 0; advance to 255, then check the wrap
    run_slot(16'h0, 1'b0, 1'b0, 8'd0, got);
    check_log("post_rst", 8'd0, 1'b0, 8'd0);
    for (int n = 0; n < 254; n++) run_slot(16'h0, 1'b0, 1'b0, 8'd0, got);
    run_slot(16'h00aa, 1'b1, 1'b1, 8'd2, got);
    check_log("wrap255", 8'd253, 1'b1, 8'd255);
    run_slot(16'h00bb, 1'b1, 1'b1, 8'd2, got);
    check_log("wrap0", 8'd254, 1'b1, 8'd0);
    run_slot(16'h0, 1'b0, 1'b1, 8'd2, got);
    check_log("wrap_rd", 8'd255, 1'b0, 8'd0);
    check("wrap_dout", 32'(got), 'haa);

    // Zero delay at ptr 2: reads last lap's value (2) before overwriting it
    run_slot(16'h0bee, 1'b1, 1'b1, 8'd0, got);
    check_log("len0", 8'd2, 1'b1, 8'd2);
    check("len0_dout", 32'(got), 2);
    check("len0_mem", mem[2], 'h0bee);

    // Overrun: tick during RDWAIT is dropped; next tick after DONE is accepted
    @(negedge clk);
    sample_tick = 1'b1; record = 1'b0; delay_reverb = 1'b0;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    #1;
    check("ovr_pulse", 32'(overrun), 1);
    @(negedge clk);
    sample_tick = 1'b0;
    #1;
    check("ovr_clear", 32'(overrun), 0);
    check("ovr_wr_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("ovr_done_valid", 32'(out_valid), 1);
    @(negedge clk);
    check("ovr_idle_busy", 32'(busy), 0);
    check("ovr_idle_valid", 32'(out_valid), 0);
    sample_tick = 1'b1;
    #1;
    check("ovr_accept_nopulse", 32'(overrun), 0);
    @(negedge clk);
    sample_tick = 1'b0;
    check("ovr_accept_busy", 32'(busy), 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("ovr_accept_pulses", pulses, 1);
    // A tick in the DONE cycle is dropped too
    sample_tick = 1'b1;
    #1;
    check("done_tick_overrun", 32'(overrun), 1);
    @(negedge clk);
    sample_tick = 1'b0;
    check("done_tick_dropped", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
